pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//   Elastic pipeline stage placed directly upstream of the enable-gated
//   datapath register in the riscv_proj pipeline. Accepts words over a
//   valid/ready handshake, buffers up to 2 words, and presents them in
//   order downstream. No combinational path from out_ready to in_ready:
//   in_ready is decoded from state flops only. Full 1 word/cycle throughput.
// PARAMETERS
//   WIDTH      8    data word width in bits
//   CNT_W      16   stall counter width (used only with SKID_PERF_CNT_EN)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-low
//   in_valid   in   1        upstream word present
//   in_ready   out  1        stage can accept; registered-state decode
//   in_data    in   WIDTH    upstream word
//   flush      in   1        synchronous discard of all buffered words
//   out_valid  out  1        word presented downstream
//   out_ready  in   1        downstream accepts
//   out_data   out  WIDTH    presented word (main slot)
//   stall_cnt  out  CNT_W    saturating stall count (SKID_PERF_CNT_EN only)
// BEHAVIOUR
//   - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Storage: main slot (drives out_data), skid slot. States EMPTY/BUSY/FULL.
//   - rst low (async): state=EMPTY, main=0, skid=0, out_valid=0,
//     in_ready=1, stall_cnt=0. Deassertion sync'd by integrator.
//   - out_valid = (state!=EMPTY); in_ready = (state!=FULL).
//   - EMPTY: in_fire -> main<=in_data, BUSY.
//   - BUSY: in_fire & out_fire -> main<=in_data, stay BUSY.
//           in_fire & !out_fire -> skid<=in_data, FULL.
//           !in_fire & out_fire -> EMPTY. Neither -> hold.
//   - FULL: in_ready=0; out_fire -> main<=skid, BUSY; else hold.
//   - Latency: word accepted cycle N appears on out_data cycle N+1 earliest.
//   - Ordering strict FIFO; no word dropped or duplicated absent flush.
//   - out_data/out_valid stable while out_valid & !out_ready.
//   - flush=1: next state EMPTY regardless of other inputs; word offered
//     same cycle is discarded even if in_ready=1 (upstream must treat as
//     consumed). Slot contents not cleared (don't-care when EMPTY).
//   - Asserting rst mid-transfer drops all words immediately.
//   - out_valid must not depend on out_ready; in_valid may drop without fire.
// CONFIGURATION
//   SKID_PERF_CNT_EN defined: stall_cnt port present; increments by 1 each
//     cycle with out_valid & !out_ready, saturates at 2^CNT_W-1, cleared
//     only by rst (not by flush).
//   SKID_PERF_CNT_EN undefined: stall_cnt port and counter logic absent;
//     all other behaviour identical.
// TESTING
//   1 rst=0 then release, in_valid=0 -> out_valid=0, in_ready=1, out_data=8'h00.
//   2 Stream 8'h01..8'h08 one/cycle, out_ready=1 -> outputs 01..08 on
//     consecutive cycles, 1-cycle latency, in_ready held 1 throughout.
//   3 out_ready=0, send 8'hA1,8'hA2 -> in_ready=0 after 2nd accept, out_data
//     holds A1; raise out_ready -> A1 then A2, in_ready returns 1.
//   4 FULL with A1/A2, assert flush 1 cycle with in_valid=1,in_data=8'hFF ->
//     next cycle out_valid=0, in_ready=1; FF never appears on out_data.
//   5 BUSY, in_fire & out_fire same cycle with 8'h55 -> state stays BUSY,
//     out_data=55 next cycle, no bubble.
//   6 SKID_PERF_CNT_EN, CNT_W=4: hold out_valid & !out_ready 20 cycles ->
//     stall_cnt=15 (saturated); flush -> still 15; rst -> 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline stage (main + skid slot) with registered in_ready.
// Define SKID_PERF_CNT_EN to add the saturating stall_cnt output and counter.
module pipe_skid_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SKID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_skid_reg: WIDTH and CNT_W must be positive");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    // Handshake outputs come straight from the state flops, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush only empties the stage; slot contents become don't-care.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef SKID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles a word waits on downstream; flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_pipe_skid_reg;

    localparam int WIDTH = 8;
`ifdef SKID_PERF_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SKID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SKID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2.
    logic [WIDTH-1:0] mq[$];
    int               mcnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            bit vld_now;
            bit acc;
            vld_now = (mq.size() != 0);
            chk("model out_valid", out_valid, vld_now);
            chk("model in_ready", in_ready, mq.size() < 2);
            if (vld_now) chk("model out_data", out_data, mq[0]);
`ifdef SKID_PERF_CNT_EN
            chk("model stall_cnt", stall_cnt, mcnt);
`endif
            if (vld_now && !out_ready && mcnt < (1 << CNT_W) - 1) mcnt++;
            acc = in_valid && (mq.size() < 2);
            if (flush) begin
                mq.delete();
            end else begin
                if (vld_now && out_ready) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #23;
        // 1: reset state
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_data", out_data, 8'h00);
        step();
        rst = 1'b1;
        step();
        chk("post-reset out_valid", out_valid, 1'b0);
        chk("post-reset in_ready", in_ready, 1'b1);

        // 2: full-rate streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            chk("stream out_data", out_data, 8'(i));
            chk("stream out_valid", out_valid, 1'b1);
            chk("stream in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        step();
        chk("stream drained", out_valid, 1'b0);

        // 3: backpressure fills the skid slot
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1;
        step();
        chk("bp first in_ready", in_ready, 1'b1);
        chk("bp first out_data", out_data, 8'hA1);
        in_data = 8'hA2;
        step();
        chk("bp full in_ready", in_ready, 1'b0);
        chk("bp full out_data", out_data, 8'hA1);
        in_data = 8'hEE;
        step();
        chk("bp hold out_data", out_data, 8'hA1);
        chk("bp hold in_ready", in_ready, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp drain second", out_data, 8'hA2);
        chk("bp drain in_ready", in_ready, 1'b1);
        step();
        chk("bp empty", out_valid, 1'b0);

        // 4: flush from FULL discards the word offered alongside it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1;
        step();
        in_data = 8'hA2;
        step();
        flush   = 1'b1;
        in_data = 8'hFF;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        chk("flush no FF", out_valid, 1'b0);

        // 5: simultaneous accept and deliver in BUSY
        in_valid = 1'b1;
        in_data  = 8'h33;
        step();
        chk("busy setup", out_data, 8'h33);
        in_data = 8'h55;
        step();
        chk("busy pass out_data", out_data, 8'h55);
        chk("busy pass out_valid", out_valid, 1'b1);
        chk("busy pass in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        step();
        chk("busy drained", out_valid, 1'b0);

        // Mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            step();
        end
        idle_inputs();
        out_ready = 1'b1;
        step();
        step();

`ifdef SKID_PERF_CNT_EN
        // 6: stall counter saturation, survives flush, cleared by reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("stall saturated", stall_cnt, 4'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stall after flush", stall_cnt, 4'd15);
        step();
        chk("stall idle hold", stall_cnt, 4'd15);
        rst = 1'b0;
        #1;
        chk("stall reset", stall_cnt, 4'd0);
        step();
        rst = 1'b1;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
